wb_buffer: RTL and testbench

Writeback buffer between the execute/memory result producers and the 8-entry × 16-bit register file write port. It accepts register-write requests over a valid/ready handshake, holds them in order in a small FIFO, and drains one entry per cycle into the register file whenever the write port is granted. Decode uses its pending-write lookup ports to detect read-after-write hazards. It can also forward the youngest pending value for a register.

---
 rtl/wb_buffer.sv | 101 ++++++++++
 tb/tb_wb_buffer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_buffer.sv
// Writeback buffer: in-order FIFO of pending register writes feeding the register file write port.
// Define WB_BYPASS_EN to build youngest-entry data forwarding on the chk*data lookup ports.
module wb_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_reg,
    input  logic [15:0]              in_data,
    input  logic                     drain_en,
    input  logic                     flush,
    output logic                     rf_write,
    output logic [2:0]               rf_writeregsel,
    output logic [15:0]              rf_writedata,
    input  logic [2:0]               chk1sel,
    input  logic [2:0]               chk2sel,
    output logic                     chk1hit,
    output logic                     chk2hit,
    output logic [15:0]              chk1data,
    output logic [15:0]              chk2data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [2:0]    ent_reg  [DEPTH];
    logic [15:0]   ent_data [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          empty;
    logic          push;
    logic          pop;

    assign empty    = (count == '0);
    assign in_ready = (count < CW'(DEPTH));
    assign push     = in_valid && in_ready && !flush;
    assign pop      = !empty && drain_en && !flush;

    assign rf_write       = pop;
    assign rf_writeregsel = empty ? '0 : ent_reg[head];
    assign rf_writedata   = empty ? '0 : ent_data[head];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage carries no reset; validity is defined solely by head/count.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_reg[tail]  <= in_reg;
            ent_data[tail] <= in_data;
        end
    end

    // Scan oldest to youngest so the last match seen is the youngest entry.
    always_comb begin
        logic [PW-1:0] idx;
        idx      = '0;
        chk1hit  = 1'b0;
        chk2hit  = 1'b0;
        chk1data = '0;
        chk2data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count) begin
                if (ent_reg[idx] == chk1sel) begin
                    chk1hit = 1'b1;
`ifdef WB_BYPASS_EN
                    chk1data = ent_data[idx];
`endif
                end
                if (ent_reg[idx] == chk2sel) begin
                    chk2hit = 1'b1;
`ifdef WB_BYPASS_EN
                    chk2data = ent_data[idx];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_buffer.sv
// Scoreboard bench for wb_buffer: stimulus queues expected drains, a negedge monitor checks them.
module tb_wb_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_reg = '0;
    logic [15:0] in_data = '0;
    logic        drain_en = 1'b0;
    logic        flush = 1'b0;
    logic        rf_write;
    logic [2:0]  rf_writeregsel;
    logic [15:0] rf_writedata;
    logic [2:0]  chk1sel = '0;
    logic [2:0]  chk2sel = '0;
    logic        chk1hit, chk2hit;
    logic [15:0] chk1data, chk2data;
    logic [2:0]  count;

    logic [18:0] exp_q[$];
    logic [18:0] mon_e;
    int unsigned n_tot  = 0;
    int unsigned n_pass = 0;

`ifdef WB_BYPASS_EN
    localparam logic [15:0] BYP_R5 = 16'h0002;
    localparam logic [15:0] BYP_R4 = 16'h4444;
`else
    localparam logic [15:0] BYP_R5 = 16'h0000;
    localparam logic [15:0] BYP_R4 = 16'h0000;
`endif

    wb_buffer #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
        .drain_en(drain_en), .flush(flush),
        .rf_write(rf_write), .rf_writeregsel(rf_writeregsel), .rf_writedata(rf_writedata),
        .chk1sel(chk1sel), .chk2sel(chk2sel),
        .chk1hit(chk1hit), .chk2hit(chk2hit),
        .chk1data(chk1data), .chk2data(chk2data),
        .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [2:0] r, input logic [15:0] d);
        in_valid = 1'b1;
        in_reg   = r;
        in_data  = d;
        exp_q.push_back({r, d});
        tick();
        in_valid = 1'b0;
    endtask

    // Monitor: every write issued to the register file must match the oldest expected entry.
    always @(negedge clk) begin
        if (rf_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tot++;
                $display("FAIL drain_unexpected: got reg %0d data 0x%0h, expected no write",
                         rf_writeregsel, rf_writedata);
            end else begin
                mon_e = exp_q.pop_front();
                check("drain_reg", 32'(rf_writeregsel), 32'(mon_e[18:16]));
                check("drain_data", 32'(rf_writedata), 32'(mon_e[15:0]));
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) tick();
        check("rst_count", 32'(count), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_rf_write", 32'(rf_write), 0);
        check("rst_regsel", 32'(rf_writeregsel), 0);
        check("rst_wdata", 32'(rf_writedata), 0);
        check("rst_chk1hit", 32'(chk1hit), 0);
        check("rst_chk2data", 32'(chk2data), 0);
        rst = 1'b1;
        tick();

        // Reset mid-traffic
        push_one(3'd1, 16'h1111);
        push_one(3'd2, 16'h2222);
        push_one(3'd3, 16'h3333);
        check("pre_rst_count", 32'(count), 3);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_count", 32'(count), 0);
        check("async_rst_rf_write", 32'(rf_write), 0);
        check("async_rst_in_ready", 32'(in_ready), 1);
        tick();
        rst = 1'b1;
        drain_en = 1'b1;
        repeat (2) tick();
        check("post_rst_count", 32'(count), 0);

        // Basic drain, no same-cycle pass-through
        in_valid = 1'b1;
        in_reg   = 3'd3;
        in_data  = 16'h1234;
        exp_q.push_back({3'd3, 16'h1234});
        #1;
        check("no_passthrough", 32'(rf_write), 0);
        tick();
        in_valid = 1'b0;
        #1;
        check("basic_rf_write", 32'(rf_write), 1);
        check("basic_regsel", 32'(rf_writeregsel), 3);
        check("basic_wdata", 32'(rf_writedata), 32'h1234);
        check("basic_count1", 32'(count), 1);
        tick();
        check("basic_count0", 32'(count), 0);

        // Full / backpressure
        drain_en = 1'b0;
        for (int i = 1; i <= 4; i++) push_one(3'(i), 16'hA000 + 16'(i));
        check("full_count", 32'(count), 4);
        check("full_in_ready", 32'(in_ready), 0);
        in_valid = 1'b1;
        in_reg   = 3'd7;
        in_data  = 16'hDEAD;
        tick();
        in_valid = 1'b0;
        check("full_reject_count", 32'(count), 4);
        in_valid = 1'b1;
        drain_en = 1'b1;
        #1;
        check("full_ready_ignores_drain", 32'(in_ready), 0);
        tick();
        in_valid = 1'b0;
        check("after_pop_in_ready", 32'(in_ready), 1);
        check("after_pop_count", 32'(count), 3);
        repeat (3) tick();
        check("full_drained_count", 32'(count), 0);

        // Wrap-around with simultaneous push/pop
        push_one(3'd0, 16'hC000);
        check("wrap_count_start", 32'(count), 1);
        for (int i = 1; i <= 10; i++) begin
            push_one(3'(i % 8), 16'hC000 + 16'(i));
            check("wrap_count", 32'(count), 1);
        end
        tick();
        check("wrap_count_end", 32'(count), 0);

        // Lookup / bypass
        drain_en = 1'b0;
        push_one(3'd5, 16'h0001);
        push_one(3'd5, 16'h0002);
        chk1sel = 3'd5;
        chk2sel = 3'd6;
        #1;
        check("chk1hit_r5", 32'(chk1hit), 1);
        check("chk1data_r5", 32'(chk1data), 32'(BYP_R5));
        check("chk2hit_r6", 32'(chk2hit), 0);
        check("chk2data_r6", 32'(chk2data), 0);

        // Flush with concurrent push
        push_one(3'd6, 16'h0666);
        check("pre_flush_count", 32'(count), 3);
        flush    = 1'b1;
        drain_en = 1'b1;
        in_valid = 1'b1;
        in_reg   = 3'd7;
        in_data  = 16'h0777;
        exp_q.delete();
        #1;
        check("flush_rf_write", 32'(rf_write), 0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_count", 32'(count), 0);
        check("flush_chk1hit", 32'(chk1hit), 0);
        repeat (3) tick();
        check("post_flush_count", 32'(count), 0);

        // Hit includes the head entry being drained
        chk1sel = 3'd4;
        push_one(3'd4, 16'h4444);
        check("drain_head_rf_write", 32'(rf_write), 1);
        check("drain_head_hit", 32'(chk1hit), 1);
        check("drain_head_data", 32'(chk1data), 32'(BYP_R4));
        tick();
        check("drained_hit", 32'(chk1hit), 0);

        repeat (2) tick();
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
